uart_rx: RTL and testbench

- UART receiver: the stage directly downstream of the fractional baud generator.
- Consumes the generator's single-cycle oversample tick on RXC (OSR ticks per bit time).
- Synchronises the asynchronous RX line, validates the start bit at mid-bit, samples DATA_W data bits LSB-first, then checks the stop bit.
- Presents each received byte with a one-cycle VALID strobe plus error strobes to the system side.

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver fed by the baud generator tick
// Optional parity stage compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_W      = 8,
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              RXC,
  input  logic              RX,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              FERR,
  output logic              PERR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(OSR) + 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OSR);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       PAR_SENSE = (PARITY_ODD != 0);
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_p_q;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   par_err_q, par_err_d;
`endif

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_err_d = par_err_q;
`endif
    case (state_q)
      // RXC is deliberately not looked at here: a tick on the edge cycle is dropped.
      S_IDLE: begin
        if (rx_p_q && !rx_s) begin
          cnt_d   = '0;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (RXC) begin
          cnt_d = cnt_inc;
          if (cnt_inc == HALF) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (RXC) begin
          cnt_d = cnt_inc;
          if (cnt_inc == FULL) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
              idx_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (RXC) begin
          cnt_d = cnt_inc;
          if (cnt_inc == FULL) begin
            cnt_d     = '0;
            par_err_d = ((^shift_q) ^ PAR_SENSE) != rx_s;
            state_d   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (RXC) begin
          cnt_d = cnt_inc;
          if (cnt_inc == FULL) begin
            cnt_d   = '0;
            data_d  = shift_q;
            ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
            valid_d = rx_s && !par_err_q;
            perr_d  = par_err_q;
`else
            valid_d = rx_s;
`endif
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q  <= '1;
      rx_p_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
      rx_p_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign BUSY  = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign PERR  = perr_q;
`else
  assign PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (define UART_RX_PARITY_EN for parity cases)
module tb_uart_rx;

  localparam int OSR = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_T = (10 + PB) * OSR;
  localparam int SAMPLE_T = OSR / 2 + (9 + PB) * OSR;

  logic       CLK, nRST, RXC, RX;
  logic [7:0] DATA;
  logic       VALID, FERR, PERR, BUSY;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   evt_ticks[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;
  int   phase = 0;
  int   t0;
  logic prev_busy = 1'b0;

  uart_rx #(.DATA_W(8), .OSR(OSR), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
    .CLK(CLK), .nRST(nRST), .RXC(RXC), .RX(RX),
    .DATA(DATA), .VALID(VALID), .FERR(FERR), .PERR(PERR), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    RXC = 1'b0;
    forever begin
      @(negedge CLK);
      phase = (phase + 1) % 4;
      RXC = (phase == 0);
    end
  end

  always @(posedge CLK) if (RXC) tick_cnt <= tick_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle is matched against the next expected frame.
  always @(negedge CLK) begin
    if (nRST && (VALID || FERR || PERR)) begin
      exp_t e;
      evt_ticks.push_back(tick_cnt);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got VALID=%0b FERR=%0b PERR=%0b DATA=0x%0h expected none",
                 VALID, FERR, PERR, DATA);
      end else begin
        e = exp_q.pop_front();
        chk("evt_data", DATA, e.data);
        chk("evt_valid", VALID, e.valid);
        chk("evt_ferr", FERR, e.ferr);
        chk("evt_perr", PERR, e.perr);
      end
      chk("busy_before_strobe", prev_busy, 1);
      chk("busy_at_strobe", BUSY, 0);
    end
    prev_busy = BUSY;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (!RXC) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    wait_ticks(OSR);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    wait_ticks(n);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) RX = 1'b1;
`endif
    send_bit(stop_b);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic v, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.valid = v; e.ferr = fe; e.perr = pe;
    exp_q.push_back(e);
  endtask

  initial begin
    nRST = 1'b0;
    RX   = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("reset_data", DATA, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_valid", VALID, 0);
    @(negedge CLK);
    nRST = 1'b1;
    idle(4);
    chk("post_reset_busy", BUSY, 0);
    chk("post_reset_ferr", FERR, 0);

    // 1: basic 0x55 frame with strobe timing
    evt_ticks.delete();
    t0 = tick_cnt;
    expect_frame(8'h55, 1, 0, 0);
    send_frame(8'h55, 1'b1, even_par(8'h55));
    idle(4);
    chk("t1_event_count", evt_ticks.size(), 1);
    if (evt_ticks.size() > 0) chk("t1_valid_tick", evt_ticks[0] - t0, SAMPLE_T);
    chk("t1_data", DATA, 8'h55);

    // 2: short low glitch is rejected at mid start bit
    RX = 1'b0;
    wait_ticks(3);
    chk("t2_busy_in_start", BUSY, 1);
    wait_ticks(2);
    RX = 1'b1;
    wait_ticks(2);
    chk("t2_busy_tick7", BUSY, 1);
    wait_ticks(1);
    chk("t2_busy_tick8", BUSY, 0);
    idle(8);
    chk("t2_data_kept", DATA, 8'h55);

    // 3: framing error, stuck low, then recovery
    expect_frame(8'hA3, 0, 1, 0);
    send_frame(8'hA3, 1'b0, even_par(8'hA3));
    RX = 1'b0;
    wait_ticks(40);
    chk("t3_no_retrigger_busy", BUSY, 0);
    chk("t3_data_a3", DATA, 8'hA3);
    idle(20);
    chk("t3_idle_busy", BUSY, 0);
    expect_frame(8'h0F, 1, 0, 0);
    send_frame(8'h0F, 1'b1, even_par(8'h0F));
    idle(4);
    chk("t3_data_0f", DATA, 8'h0F);

    // 4: back-to-back frames with no idle time
    evt_ticks.delete();
    expect_frame(8'h00, 1, 0, 0);
    expect_frame(8'hFF, 1, 0, 0);
    send_frame(8'h00, 1'b1, even_par(8'h00));
    send_frame(8'hFF, 1'b1, even_par(8'hFF));
    idle(4);
    chk("t4_event_count", evt_ticks.size(), 2);
    if (evt_ticks.size() > 1) chk("t4_spacing", evt_ticks[1] - evt_ticks[0], FRAME_T);
    chk("t4_data_ff", DATA, 8'hFF);

    // 5: asynchronous reset in the middle of data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h3C >> i) & 1) != 0);
    RX = 1'b1;
    wait_ticks(OSR / 2);
    chk("t5_busy_mid", BUSY, 1);
    nRST = 1'b0;
    #1;
    chk("t5_rst_data", DATA, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_valid", VALID, 0);
    chk("t5_rst_ferr", FERR, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    idle(4);
    expect_frame(8'h3C, 1, 0, 0);
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    idle(4);
    chk("t5_data_3c", DATA, 8'h3C);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good then bad parity bit
    expect_frame(8'h07, 1, 0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 0, 0, 1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    chk("t6_data_07", DATA, 8'h07);
`endif

    idle(20);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
